// File: rtl/txburst_gen_pkg.sv
// Shared definitions for the TX burst generator: sequencer state encodings,
// default sample divider, gain constants and the quarter-wave table generator.
package txburst_gen_pkg;

  // Sequencer state encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // 2 MHz system clock / 100 kHz sample rate
  localparam int CLK_DIV_DEFAULT = 20;

  // Burst/gap length counter width
  localparam int LEN_W = 16;

  // Amplitude control: unsigned Q1.11, 2048 = unity
  localparam int AMPL_W     = 12;
  localparam int UNITY_GAIN = 2048;
  localparam int GAIN_SHIFT = 11;

  localparam real HALF_PI = 1.5707963267948966;

  // Largest magnitude emitted; the most negative code is never produced
  function automatic int full_scale(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Quarter-wave table entry i of 2^lut_aw+1: round(full_scale * sin(pi/2 * i / 2^lut_aw)).
  // Only ever evaluated with constant arguments, so it folds into ROM contents.
  function automatic int qlut_entry(input int i, input int lut_aw, input int out_w);
    real ang;
    real v;
    ang = HALF_PI * real'(i) / real'(1 << lut_aw);
    v   = real'(full_scale(out_w)) * $sin(ang);
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/txburst_gen_sine_qlut.sv
// sine_qlut: registered quarter-wave sine ROM with quadrant mirror/negate.
// Takes the top LUT_AW+2 phase bits; output updates one clock after ld_i.
// When gate_i is low the loaded sample is forced to zero (silence).
module sine_qlut
  import txburst_gen_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ld_i,
  input  logic                    gate_i,
  input  logic [LUT_AW+1:0]       phase_i,
  output logic signed [OUT_W-1:0] sample_o
);

  localparam int N  = 1 << LUT_AW;
  localparam int MW = OUT_W - 1;
  localparam logic [LUT_AW:0] N_ADDR = (LUT_AW + 1)'(N);

  logic [MW-1:0]           rom [0:N];
  logic [1:0]              quad;
  logic [LUT_AW-1:0]       idx;
  logic [LUT_AW:0]         addr;
  logic [MW-1:0]           mag;
  logic signed [OUT_W-1:0] pos;
  logic signed [OUT_W-1:0] val;
  logic signed [OUT_W-1:0] sample_q;

  for (genvar g = 0; g <= N; g++) begin : g_rom
    assign rom[g] = MW'(qlut_entry(g, LUT_AW, OUT_W));
  end

  // Quadrant decode: odd quadrants read the table backwards, upper half negates
  always_comb begin
    quad = phase_i[LUT_AW+1 -: 2];
    idx  = phase_i[LUT_AW-1:0];
    addr = quad[0] ? (N_ADDR - {1'b0, idx}) : {1'b0, idx};
    mag  = rom[addr];
    pos  = $signed({1'b0, mag});
    val  = quad[1] ? -pos : pos;
  end

  // Output register: loads once per sample, holds between samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= '0;
    end else if (ld_i) begin
      sample_q <= gate_i ? val : '0;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/txburst_gen.sv
// txburst_gen: TX sine burst generator (NCO + BURST/GAP sequencer).
// Sample tick every CLK_DIV clocks; tx, txactive, burststart and endata are
// registered together one clock after the tick.
// Build option TXBURST_AMPL_EN: adds the ampl port and a gain stage, which
// delays every output by one more clock so endata stays aligned with tx.
module txburst_gen
  import txburst_gen_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PHASE_W-1:0]      freqword,
  input  logic [LEN_W-1:0]        burstlen,
  input  logic [LEN_W-1:0]        gaplen,
`ifdef TXBURST_AMPL_EN
  input  logic [AMPL_W-1:0]       ampl,
`endif
  output logic                    endata,
  output logic signed [OUT_W-1:0] tx,
  output logic                    txactive,
  output logic                    burststart
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_q;
  logic               tick;

  logic [1:0]         state_q,  state_d;
  logic [LEN_W-1:0]   cnt_q,    cnt_d;
  logic [LEN_W-1:0]   bl_q,     bl_d;
  logic [LEN_W-1:0]   gl_q,     gl_d;
  logic [PHASE_W-1:0] phase_q,  phase_d;
  logic               first_q,  first_d;

  logic               gate;
  logic               start;
  logic               begin_burst;

  logic signed [OUT_W-1:0] s1_tx;
  logic               act1_q;
  logic               bs1_q;
  logic               end1_q;

  assign tick = (div_q == DIV_LAST);

  // Free-running sample divider, also runs in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Sequencer next-state: acts only on ticks. Every entry into a burst goes
  // through begin_burst so lengths are latched and phase cleared in one place.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bl_d        = bl_q;
    gl_d        = gl_q;
    phase_d     = phase_q;
    first_d     = first_q;
    gate        = 1'b0;
    start       = 1'b0;
    begin_burst = 1'b0;
    if (tick) begin
      if (!enable) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        phase_d = '0;
        first_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            begin_burst = 1'b1;
          end
          ST_BURST: begin
            gate    = 1'b1;
            start   = first_q;
            first_d = 1'b0;
            phase_d = phase_q + freqword;
            if (bl_q != '0) begin
              if (cnt_q == bl_q - LEN_W'(1)) begin
                cnt_d = '0;
                if (gl_q == '0) begin
                  begin_burst = 1'b1;
                end else begin
                  state_d = ST_GAP;
                end
              end else begin
                cnt_d = cnt_q + LEN_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (cnt_q == gl_q - LEN_W'(1)) begin
              begin_burst = 1'b1;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phase_d = '0;
            first_d = 1'b0;
          end
        endcase
      end
    end
    if (begin_burst) begin
      state_d = ST_BURST;
      first_d = 1'b1;
      cnt_d   = '0;
      phase_d = '0;
      bl_d    = burstlen;
      gl_d    = gaplen;
    end
  end

  // Sequencer and phase accumulator registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bl_q    <= '0;
      gl_q    <= '0;
      phase_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bl_q    <= bl_d;
      gl_q    <= gl_d;
      phase_q <= phase_d;
      first_q <= first_d;
    end
  end

  sine_qlut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_qlut (
    .clk_i    (clock),
    .rst_i    (reset),
    .ld_i     (tick),
    .gate_i   (gate),
    .phase_i  (phase_q[PHASE_W-1 -: LUT_AW+2]),
    .sample_o (s1_tx)
  );

  // Status flags registered alongside the LUT output; endata follows every tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act1_q <= 1'b0;
      bs1_q  <= 1'b0;
      end1_q <= 1'b0;
    end else begin
      end1_q <= tick;
      if (tick) begin
        act1_q <= gate;
        bs1_q  <= start;
      end
    end
  end

`ifdef TXBURST_AMPL_EN
  logic [AMPL_W:0]         gain;
  logic signed [OUT_W+12:0] prod;
  logic signed [OUT_W-1:0] tx_q;
  logic                    act2_q;
  logic                    bs2_q;
  logic                    end2_q;

  // Gain above unity is clamped to unity
  always_comb begin
    gain = (ampl > AMPL_W'(UNITY_GAIN)) ? (AMPL_W + 1)'(UNITY_GAIN) : {1'b0, ampl};
    prod = (OUT_W + 13)'(s1_tx) * (OUT_W + 13)'($signed({1'b0, gain}));
  end

  // Gain stage: arithmetic shift floors toward -inf; flags delayed to match
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_q   <= '0;
      act2_q <= 1'b0;
      bs2_q  <= 1'b0;
      end2_q <= 1'b0;
    end else begin
      tx_q   <= OUT_W'(prod >>> GAIN_SHIFT);
      act2_q <= act1_q;
      bs2_q  <= bs1_q;
      end2_q <= end1_q;
    end
  end

  assign tx         = tx_q;
  assign txactive   = act2_q;
  assign burststart = bs2_q;
  assign endata     = end2_q;
`else
  assign tx         = s1_tx;
  assign txactive   = act1_q;
  assign burststart = bs1_q;
  assign endata     = end1_q;
`endif

endmodule

// File: tb/tb_txburst_gen.sv
// Testbench for txburst_gen: sample-level behavioural model compared every
// clock, plus hand-computed sample sequences for each directed scenario.
module tb_txburst_gen;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [31:0]        freqword = 32'h4000_0000;
  logic [15:0]        burstlen = 16'd0;
  logic [15:0]        gaplen = 16'd0;
`ifdef TXBURST_AMPL_EN
  logic [11:0]        ampl = 12'd2048;
`endif
  logic               endata;
  logic signed [11:0] tx;
  logic               txactive;
  logic               burststart;

  int n_checks = 0;
  int n_errors = 0;

  txburst_gen #(
    .CLK_DIV (20),
    .PHASE_W (32),
    .LUT_AW  (8),
    .OUT_W   (12)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .freqword   (freqword),
    .burstlen   (burstlen),
    .gaplen     (gaplen),
`ifdef TXBURST_AMPL_EN
    .ampl       (ampl),
`endif
    .endata     (endata),
    .tx         (tx),
    .txactive   (txactive),
    .burststart (burststart)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Ideal sine of the truncated 10-bit phase, rounded half away from zero
  function automatic int sine_exp(input logic [31:0] ph);
    real a;
    real v;
    a = 2.0 * 3.14159265358979323846 * real'(int'(ph[31:22])) / 1024.0;
    v = 2047.0 * $sin(a);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // ---------------- behavioural model (one step per sample) ----------------
  int          cyc;
  int          m_mode;     // 0 idle, 1 burst, 2 gap
  bit          m_new;
  int          m_left, m_gleft, m_L, m_G;
  logic [31:0] m_ph;
  int          e1_tx, o_tx;
  bit          e1_act, e1_bs, e1_end, o_act, o_bs, o_end;

  task automatic model_new_burst();
    m_new  = 1'b1;
    m_ph   = 32'd0;
    m_L    = int'(burstlen);
    m_G    = int'(gaplen);
    m_left = m_L;
  endtask

  task automatic model_sample();
    e1_tx  = 0;
    e1_act = 1'b0;
    e1_bs  = 1'b0;
    if (!enable) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      model_new_burst();
    end else if (m_mode == 1) begin
      e1_bs  = m_new;
      m_new  = 1'b0;
      e1_act = 1'b1;
      e1_tx  = sine_exp(m_ph);
      m_ph   = m_ph + freqword;
      if (m_L != 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_G == 0) model_new_burst();
          else begin
            m_mode  = 2;
            m_gleft = m_G;
          end
        end
      end
    end else begin
      m_gleft--;
      if (m_gleft == 0) begin
        m_mode = 1;
        model_new_burst();
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc = 0; m_mode = 0; m_new = 1'b0; m_ph = 32'd0;
      m_left = 0; m_gleft = 0; m_L = 0; m_G = 0;
      e1_tx = 0; e1_act = 1'b0; e1_bs = 1'b0; e1_end = 1'b0;
      o_tx = 0; o_act = 1'b0; o_bs = 1'b0; o_end = 1'b0;
    end else begin
`ifdef TXBURST_AMPL_EN
      begin
        int g;
        g = (int'(ampl) > 2048) ? 2048 : int'(ampl);
        o_tx  = (e1_tx * g) >>> 11;
        o_act = e1_act;
        o_bs  = e1_bs;
        o_end = e1_end;
      end
`endif
      cyc++;
      e1_end = (cyc % 20 == 0);
      if (e1_end) model_sample();
`ifndef TXBURST_AMPL_EN
      o_tx  = e1_tx;
      o_act = e1_act;
      o_bs  = e1_bs;
      o_end = e1_end;
`endif
    end
  end

  // ---------------- compare process + sample log ----------------
  int q_tx[$];
  int q_act[$];
  int q_bs[$];
  int n_end;

  always @(negedge clock) begin
    if (!reset) begin
      chk("tx", 32'(tx), o_tx);
      chk("txactive", 32'(txactive), 32'(o_act));
      chk("burststart", 32'(burststart), 32'(o_bs));
      chk("endata", 32'(endata), 32'(o_end));
      if (endata === 1'b1) begin
        q_tx.push_back(int'(tx));
        q_act.push_back(int'(txactive));
        q_bs.push_back(int'(burststart));
        n_end++;
      end
    end
  end

  task automatic clear_log();
    q_tx.delete();
    q_act.delete();
    q_bs.delete();
    n_end = 0;
  endtask

  task automatic samples(input int n);
    repeat (n * 20) @(negedge clock);
  endtask

  task automatic check_q(input string tag, input int i, input int etx, input int eact, input int ebs);
    if (i >= q_tx.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_len: got %0d samples, expected more than %0d", tag, q_tx.size(), i);
    end else begin
      chk($sformatf("%s_tx[%0d]", tag, i), q_tx[i], etx);
      chk($sformatf("%s_act[%0d]", tag, i), q_act[i], eact);
      chk($sformatf("%s_bs[%0d]", tag, i), q_bs[i], ebs);
    end
  endtask

  int seq4[4]   = '{0, 2047, 0, -2047};
  int t2_tx[9]  = '{0, 0, 2047, 0, -2047, 0, 2047, 0, -2047};
  int t2_act[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  int t2_bs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
  int t4_tx[9]  = '{0, 0, 2047, 0, 0, 0, 0, 2047, 0};
  int t4_act[9] = '{0, 1, 1, 0, 0, 0, 1, 1, 1};
  int t4_bs[9]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
  int t5_tx[15]  = '{0, 0, 2047, 0, -2047, 0, 0, 0, 2047, 0, 0, 2047, 0, 0, 2047};
  int t5_act[15] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  int t5_bs[15]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
`ifdef TXBURST_AMPL_EN
  int t6_tx[5]  = '{0, 0, 1023, 0, -1024};
  int t6b_tx[5] = '{0, 0, 2047, 0, -2047};
  int t6_act[5] = '{0, 1, 1, 1, 1};
  int t6_bs[5]  = '{0, 1, 0, 0, 0};
`endif

  initial begin
    clear_log();
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 0);
    chk("rst_endata", 32'(endata), 0);
    chk("rst_txactive", 32'(txactive), 0);
    chk("rst_burststart", 32'(burststart), 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);   // stimulus changes land mid-sample

    // 1: disabled -> silent, endata every 20 clocks
    clear_log();
    samples(3);
    chk("t1_endata_count", n_end, 3);
    for (int i = 0; i < 3; i++) check_q("t1", i, 0, 0, 0);

    // 2: continuous wave at fs/4
    clear_log();
    burstlen = 16'd0;
    enable   = 1'b1;
    samples(9);
    for (int i = 0; i < 9; i++) check_q("t2", i, t2_tx[i], t2_act[i], t2_bs[i]);

    // 3: 8-sample bursts with 4-sample gaps
    enable = 1'b0;
    samples(2);
    clear_log();
    burstlen = 16'd8;
    gaplen   = 16'd4;
    enable   = 1'b1;
    samples(25);
    check_q("t3", 0, 0, 0, 0);
    for (int i = 1; i < 25; i++) begin
      int p;
      p = (i - 1) % 12;
      check_q("t3", i, (p < 8) ? seq4[p % 4] : 0, (p < 8) ? 1 : 0, (p == 0) ? 1 : 0);
    end

    // 4: drop enable mid-burst, then re-enable
    enable = 1'b0;
    samples(2);
    burstlen = 16'd0;
    gaplen   = 16'd0;
    clear_log();
    enable = 1'b1;
    samples(3);
    enable = 1'b0;
    samples(2);
    enable = 1'b1;
    samples(4);
    for (int i = 0; i < 9; i++) check_q("t4", i, t4_tx[i], t4_act[i], t4_bs[i]);

    // 5: burst length changed mid-burst only affects the next burst
    enable = 1'b0;
    samples(2);
    burstlen = 16'd5;
    gaplen   = 16'd1;
    clear_log();
    enable = 1'b1;
    samples(3);
    burstlen = 16'd2;
    samples(12);
    for (int i = 0; i < 15; i++) check_q("t5", i, t5_tx[i], t5_act[i], t5_bs[i]);

`ifdef TXBURST_AMPL_EN
    // 6: half gain, then over-range gain clamps to unity
    enable = 1'b0;
    samples(2);
    burstlen = 16'd0;
    gaplen   = 16'd0;
    ampl     = 12'd1024;
    clear_log();
    enable = 1'b1;
    samples(5);
    for (int i = 0; i < 5; i++) check_q("t6", i, t6_tx[i], t6_act[i], t6_bs[i]);
    enable = 1'b0;
    samples(2);
    ampl = 12'd4000;
    clear_log();
    enable = 1'b1;
    samples(5);
    for (int i = 0; i < 5; i++) check_q("t6b", i, t6b_tx[i], t6_act[i], t6_bs[i]);
    ampl = 12'd2048;
`endif

    // Reset mid-burst: immediate silence, restart from IDLE
    enable = 1'b0;
    samples(2);
    burstlen = 16'd0;
    gaplen   = 16'd0;
    enable   = 1'b1;
    samples(3);
    chk("pre_reset_tx", 32'(tx), 2047);
    reset = 1'b1;
    #1;
    chk("async_reset_tx", 32'(tx), 0);
    chk("async_reset_txactive", 32'(txactive), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    clear_log();
    samples(2);
    check_q("rst_restart", 0, 0, 0, 0);
    check_q("rst_restart", 1, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
